// File: rtl/serial_digit_rx.sv
// UART receiver collecting ASCII decimal digits into a packed BCD word, with
// parity/stop checking, CR/LF or idle-line message close and a held valid/ack handshake.
module serial_digit_rx #(
  parameter  int unsigned OVERSAMPLE  = 16,
  parameter  int unsigned MAX_DIGITS  = 16,
  parameter  int unsigned PARITY_MODE = 0,
  parameter  int unsigned IDLE_BITS   = 10,
  localparam int unsigned NW          = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    IN_clk,
  input  logic                    IN_rst_n,
  input  logic                    IN_ser,
  input  logic                    IN_ack,
  output logic [4*MAX_DIGITS-1:0] OUT_data,
  output logic [NW-1:0]           OUT_number,
  output logic [NW-1:0]           OUT_off_number,
  output logic                    OUT_valid,
  output logic [3:0]              OUT_err
);

  localparam int unsigned DW       = 4 * MAX_DIGITS;
  localparam int unsigned TW       = $clog2(OVERSAMPLE);
  localparam int unsigned IDLE_CYC = IDLE_BITS * OVERSAMPLE;
  localparam int unsigned IW       = $clog2(IDLE_CYC + 1);

  localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYC - 1);
  localparam logic [NW-1:0] NUM_MAX    = NW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic          sync1_q, sync2_q;
  logic          line;

  state_e        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          par_bad_q;
  logic          char_done_q;
  logic [7:0]    char_byte_q;
  logic          char_par_q;
  logic          char_frm_q;

  logic [DW-1:0] data_q,  data_d;
  logic [NW-1:0] num_q,   num_d;
  logic [3:0]    err_q,   err_d;
  logic          valid_q, valid_d;
  logic          open_q,  open_d;
  logic [IW-1:0] idle_q,  idle_d;

  logic          exp_par;
  logic          is_digit, is_crlf, is_bad, opening, msg_live;

  // Idle-high reset value keeps a reset release from looking like a start bit.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= IN_ser;
      sync2_q <= sync1_q;
    end
  end

  assign line    = sync2_q;
  assign exp_par = (PARITY_MODE == 2) ? ~^shreg_q : ^shreg_q;

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      par_bad_q   <= 1'b0;
      char_done_q <= 1'b0;
      char_byte_q <= '0;
      char_par_q  <= 1'b0;
      char_frm_q  <= 1'b0;
    end else begin
      char_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The cycle that first sees the low line counts as tick 0.
          if (!line) begin
            state_q <= S_START;
            tick_q  <= TW'(1);
          end
        end
        S_START: begin
          if (tick_q == TICK_START) begin
            tick_q <= '0;
            if (line) begin
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              bit_q     <= '0;
              par_bad_q <= 1'b0;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            shreg_q <= {line, shreg_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_q    <= '0;
            par_bad_q <= (line != exp_par);
            state_q   <= S_STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_q      <= '0;
            char_done_q <= 1'b1;
            char_byte_q <= shreg_q;
            char_par_q  <= par_bad_q;
            char_frm_q  <= !line;
            state_q     <= line ? S_IDLE : S_WAIT_HIGH;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (line) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign is_digit = (char_byte_q >= 8'h30) && (char_byte_q <= 8'h39);
  assign is_crlf  = (char_byte_q == 8'h0D) || (char_byte_q == 8'h0A);
  assign is_bad   = char_par_q | char_frm_q;
  // A clean CR/LF with nothing open is swallowed without opening a message.
  assign opening  = char_done_q && !valid_q && !open_q && !(is_crlf && !is_bad);
  assign msg_live = open_q || opening;

  always_comb begin
    data_d  = data_q;
    num_d   = num_q;
    err_d   = err_q;
    valid_d = valid_q;
    open_d  = open_q;
    idle_d  = idle_q;

    if (valid_q && IN_ack) begin
      valid_d = 1'b0;
    end

    if (char_done_q) begin
      if (valid_q) begin
        err_d[3] = 1'b1;
      end else if (msg_live) begin
        if (!open_q) begin
          data_d = '0;
          num_d  = '0;
          err_d  = '0;
          open_d = 1'b1;
        end
        if (is_bad) begin
          err_d[1] = err_d[1] | char_par_q;
          err_d[0] = err_d[0] | char_frm_q;
        end else if (is_digit) begin
          if (num_d < NUM_MAX) begin
            data_d      = data_d << 4;
            data_d[3:0] = char_byte_q[3:0];
            num_d       = num_d + 1'b1;
          end else begin
            err_d[2] = 1'b1;
          end
        end else if (is_crlf) begin
          open_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
    end

    if (open_d && (state_q == S_IDLE) && line) begin
      if (idle_q == IDLE_LAST) begin
        idle_d  = '0;
        open_d  = 1'b0;
        valid_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      data_q  <= '0;
      num_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      open_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      data_q  <= data_d;
      num_q   <= num_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      open_q  <= open_d;
      idle_q  <= idle_d;
    end
  end

  assign OUT_data       = data_q;
  assign OUT_number     = num_q;
  assign OUT_off_number = NUM_MAX - num_q;
  assign OUT_valid      = valid_q;
  assign OUT_err        = err_q;

endmodule

// File: tb/tb_serial_digit_rx.sv
// Bench for serial_digit_rx: one no-parity and one even-parity instance, directed
// cases plus random digit messages checked against a message-level model.
module tb_serial_digit_rx;

  localparam int OVS   = 16;
  localparam int MAXD  = 4;
  localparam int IDLEB = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser0 = 1'b1, ser1 = 1'b1;
  logic        ack0 = 1'b0, ack1 = 1'b0;
  logic [15:0] data0, data1;
  logic [2:0]  num0, num1, off0, off1;
  logic        valid0, valid1;
  logic [3:0]  err0, err1;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // Message-level model: digits held, open/valid flags, sticky error bits.
  int          m_dig [2][MAXD];
  int          m_cnt [2];
  bit          m_open [2];
  bit          m_valid [2];
  logic [3:0]  m_err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_digit_rx #(.OVERSAMPLE(OVS), .MAX_DIGITS(MAXD), .PARITY_MODE(0), .IDLE_BITS(IDLEB)) dut0 (
    .IN_clk(clk), .IN_rst_n(rst_n), .IN_ser(ser0), .IN_ack(ack0),
    .OUT_data(data0), .OUT_number(num0), .OUT_off_number(off0),
    .OUT_valid(valid0), .OUT_err(err0)
  );

  serial_digit_rx #(.OVERSAMPLE(OVS), .MAX_DIGITS(MAXD), .PARITY_MODE(1), .IDLE_BITS(IDLEB)) dut1 (
    .IN_clk(clk), .IN_rst_n(rst_n), .IN_ser(ser1), .IN_ack(ack1),
    .OUT_data(data1), .OUT_number(num1), .OUT_off_number(off1),
    .OUT_valid(valid1), .OUT_err(err1)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_open[i] = 0; m_valid[i] = 0; m_err[i] = '0;
    end
  endtask

  task automatic m_char(input int inst, input logic [7:0] b, input bit par_bad, input bit frm_bad);
    bit bad;
    bit crlf;
    bad  = par_bad | frm_bad;
    crlf = (b == 8'h0D) || (b == 8'h0A);
    if (m_valid[inst]) begin
      m_err[inst][3] = 1'b1;
      return;
    end
    if (!m_open[inst]) begin
      if (crlf && !bad) return;
      m_open[inst] = 1; m_cnt[inst] = 0; m_err[inst] = '0;
    end
    if (bad) begin
      if (par_bad) m_err[inst][1] = 1'b1;
      if (frm_bad) m_err[inst][0] = 1'b1;
    end else if (b >= 8'h30 && b <= 8'h39) begin
      if (m_cnt[inst] < MAXD) begin
        m_dig[inst][m_cnt[inst]] = int'(b) - 48;
        m_cnt[inst]++;
      end else begin
        m_err[inst][2] = 1'b1;
      end
    end else if (crlf) begin
      m_open[inst] = 0; m_valid[inst] = 1;
    end
  endtask

  task automatic m_idle(input int inst);
    if (m_open[inst]) begin
      m_open[inst] = 0; m_valid[inst] = 1;
    end
  endtask

  function automatic int m_value(input int inst);
    int v;
    v = 0;
    for (int i = 0; i < m_cnt[inst]; i++) v = v * 16 + m_dig[inst][i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int inst, input string tag);
    logic [15:0] d;
    logic [2:0]  n, o;
    logic        v;
    logic [3:0]  e;
    d = (inst == 1) ? data1  : data0;
    n = (inst == 1) ? num1   : num0;
    o = (inst == 1) ? off1   : off0;
    v = (inst == 1) ? valid1 : valid0;
    e = (inst == 1) ? err1   : err0;
    chk({tag, ".data"},   32'(d), 32'(m_value(inst)));
    chk({tag, ".number"}, 32'(n), 32'(m_cnt[inst]));
    chk({tag, ".off"},    32'(o), 32'(MAXD - m_cnt[inst]));
    chk({tag, ".valid"},  32'(v), 32'(m_valid[inst]));
    chk({tag, ".err"},    32'(e), 32'(m_err[inst]));
  endtask

  task automatic set_ser(input int inst, input logic v);
    if (inst == 1) ser1 = v; else ser0 = v;
  endtask

  task automatic drive_bit(input int inst, input logic v);
    set_ser(inst, v);
    repeat (OVS) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input int inst, input logic [7:0] b, input bit flip_par, input bit stop_zero);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, b[i]);
    if (inst == 1) drive_bit(inst, (^b) ^ flip_par);
    drive_bit(inst, !stop_zero);
    if (stop_zero) drive_bit(inst, 1'b1);
    m_char(inst, b, flip_par && (inst == 1), stop_zero);
  endtask

  task automatic send_str(input int inst, input string s);
    for (int i = 0; i < s.len(); i++) send_char(inst, s[i], 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input int inst);
    int n;
    n = 0;
    while (!((inst == 1) ? valid1 : valid0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack_msg(input int inst, input string tag);
    if (inst == 1) ack1 = 1'b1; else ack0 = 1'b1;
    chk({tag, ".valid_during_ack"}, 32'((inst == 1) ? valid1 : valid0), 32'(m_valid[inst]));
    @(posedge clk); #1;
    if (inst == 1) ack1 = 1'b0; else ack0 = 1'b0;
    m_valid[inst] = 0;
    check_inst(inst, {tag, ".after_ack"});
  endtask

  initial begin
    int unsigned t0;
    int          len;
    logic [7:0]  b;

    m_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_inst(0, "reset0");
    check_inst(1, "reset1");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // "12",CR then ack
    send_str(0, "12"); send_char(0, 8'h0D, 1'b0, 1'b0);
    wait_valid(0);
    check_inst(0, "msg12");
    ack_msg(0, "msg12");

    // overflow
    send_str(0, "12345"); send_char(0, 8'h0D, 1'b0, 1'b0);
    wait_valid(0);
    check_inst(0, "overflow");
    ack_msg(0, "overflow");

    // 5-tick glitch must not open anything
    ser0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 ser0 = 1'b1;
    repeat (3 * OVS) @(posedge clk);
    #1;
    check_inst(0, "glitch");
    send_str(0, "7"); send_char(0, 8'h0D, 1'b0, 1'b0);
    wait_valid(0);
    check_inst(0, "after_glitch");
    ack_msg(0, "after_glitch");

    // even parity: '7' with bad parity bit, then '8', CR
    send_char(1, "7", 1'b1, 1'b0); send_str(1, "8"); send_char(1, 8'h0D, 1'b0, 1'b0);
    wait_valid(1);
    check_inst(1, "parity");
    ack_msg(1, "parity");

    // framing error on '5', then '6', CR
    send_char(1, "5", 1'b0, 1'b1); send_str(1, "6"); send_char(1, 8'h0D, 1'b0, 1'b0);
    wait_valid(1);
    check_inst(1, "framing");
    ack_msg(1, "framing");

    // Idle close: stop sample lands 2 sync cycles + (OVS/2-1) + 9 bit-times after
    // the start-bit drive; valid shows IDLEB*OVS cycles later plus one register stage.
    t0 = cyc;
    send_str(0, "9");
    wait_valid(0);
    chk("idle.rise_cycle", 32'(cyc - t0), 32'(2 + OVS / 2 - 1 + 9 * OVS + IDLEB * OVS + 1));
    m_idle(0);
    check_inst(0, "idle");
    send_str(0, "3");
    check_inst(0, "overrun");
    ack_msg(0, "overrun");

    // reset in the middle of the data bits of '4'
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0); drive_bit(0, 1'b0); drive_bit(0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_inst(0, "async_reset0");
    check_inst(1, "async_reset1");
    ser0 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2 * OVS) @(posedge clk);
    #1;
    send_str(0, "4"); send_char(0, 8'h0D, 1'b0, 1'b0);
    wait_valid(0);
    check_inst(0, "after_reset");
    ack_msg(0, "after_reset");

    // random messages
    for (int m = 0; m < 8; m++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) < 7) begin
          b = 8'h30 + 8'($urandom_range(0, 9));
        end else begin
          b = 8'($urandom_range(0, 255));
          while ((b >= 8'h30 && b <= 8'h39) || b == 8'h0D || b == 8'h0A) b = 8'($urandom_range(0, 255));
        end
        send_char(0, b, 1'b0, 1'b0);
      end
      send_char(0, ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D, 1'b0, 1'b0);
      wait_valid(0);
      check_inst(0, "rand0");
      ack_msg(0, "rand0");
    end

    for (int m = 0; m < 3; m++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        b = 8'h30 + 8'($urandom_range(0, 9));
        send_char(1, b, ($urandom_range(0, 4) == 0), 1'b0);
      end
      send_char(1, 8'h0D, 1'b0, 1'b0);
      wait_valid(1);
      check_inst(1, "rand1");
      ack_msg(1, "rand1");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
